// File: rtl/stfq_rank_compute.sv
// stfq_rank_compute: Start-Time Fair Queuing rank stage (2-stage pipeline) feeding flow_pifo enqueue.
// Define STFQ_WEIGHT_EN to add per-flow weight (length right-shift) configuration ports.
module stfq_rank_compute #(
   parameter int  NUM_FLOWS      = 16,
   parameter int  PRIORITY_WIDTH = 16,
   parameter int  LENGTH_WIDTH   = 11,
   localparam int FLOW_ID_WIDTH  = $clog2(NUM_FLOWS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      i__pkt_valid,
   output logic                      o__pkt_ready,
   input  logic [FLOW_ID_WIDTH-1:0]  i__pkt_flow_id,
   input  logic [LENGTH_WIDTH-1:0]   i__pkt_length,
   output logic                      o__enqueue,
   output logic [PRIORITY_WIDTH-1:0] o__enqueue_priority,
   output logic [FLOW_ID_WIDTH-1:0]  o__enqueue_flow_id,
   input  logic                      i__enqueue_ready,
   input  logic                      i__dequeue_valid,
   input  logic [PRIORITY_WIDTH-1:0] i__dequeue_priority,
   output logic [PRIORITY_WIDTH-1:0] o__virtual_time,
`ifdef STFQ_WEIGHT_EN
   input  logic                      i__cfg_wr,
   input  logic [FLOW_ID_WIDTH-1:0]  i__cfg_flow_id,
   input  logic [2:0]                i__cfg_shift,
`endif
   output logic                      o__overflow
);

   logic                      s1_valid_q, s1_valid_d;
   logic [FLOW_ID_WIDTH-1:0]  s1_flow_q, s1_flow_d;
   logic [LENGTH_WIDTH-1:0]   s1_len_q, s1_len_d;
   logic                      enq_q, enq_d;
   logic [PRIORITY_WIDTH-1:0] prio_q, prio_d;
   logic [FLOW_ID_WIDTH-1:0]  flow_q, flow_d;
   logic [PRIORITY_WIDTH-1:0] vtime_q, vtime_d;
   logic                      ovf_q, ovf_d;
   logic [PRIORITY_WIDTH-1:0] last_finish_q [NUM_FLOWS];
   logic [PRIORITY_WIDTH-1:0] last_finish_d [NUM_FLOWS];

   logic                      s2_advance;
   logic                      accept;
   logic                      tbl_we;
   logic [PRIORITY_WIDTH-1:0] lf_rd;
   logic [PRIORITY_WIDTH-1:0] start;
   logic [PRIORITY_WIDTH-1:0] finish;
   logic [PRIORITY_WIDTH:0]   finish_wide;
   logic [LENGTH_WIDTH-1:0]   eff_len;

   assign s2_advance   = ~enq_q | i__enqueue_ready;
   assign o__pkt_ready = ~s1_valid_q | s2_advance;
   assign accept       = i__pkt_valid & o__pkt_ready;
   // The table is written exactly when S1 moves into S2, so a same-flow packet
   // entering S1 on that edge reads the fresh finish tag next cycle.
   assign tbl_we       = s1_valid_q & s2_advance;

   assign lf_rd = last_finish_q[s1_flow_q];
   assign start = (vtime_q > lf_rd) ? vtime_q : lf_rd;

`ifdef STFQ_WEIGHT_EN
   logic [2:0] shift_q [NUM_FLOWS];
   logic [2:0] shift_d [NUM_FLOWS];

   always_comb begin
      shift_d = shift_q;
      if (i__cfg_wr) shift_d[i__cfg_flow_id] = i__cfg_shift;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) shift_q <= '{default: '0};
      else        shift_q <= shift_d;
   end

   assign eff_len = s1_len_q >> shift_q[s1_flow_q];
`else
   assign eff_len = s1_len_q;
`endif

   assign finish_wide = {1'b0, start} + (PRIORITY_WIDTH+1)'(eff_len);
   assign finish      = finish_wide[PRIORITY_WIDTH] ? '1 : finish_wide[PRIORITY_WIDTH-1:0];

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_flow_d  = s1_flow_q;
      s1_len_d   = s1_len_q;
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_flow_d  = i__pkt_flow_id;
         s1_len_d   = i__pkt_length;
      end else if (s2_advance) begin
         s1_valid_d = 1'b0;
      end
   end

   always_comb begin
      enq_d  = enq_q;
      prio_d = prio_q;
      flow_d = flow_q;
      if (s2_advance) begin
         enq_d = s1_valid_q;
         if (s1_valid_q) begin
            prio_d = start;
            flow_d = s1_flow_q;
         end
      end
   end

   always_comb begin
      last_finish_d = last_finish_q;
      if (tbl_we) last_finish_d[s1_flow_q] = finish;
   end

   // Virtual time is monotonic: stale dequeue priorities never pull it back.
   assign vtime_d = (i__dequeue_valid && (i__dequeue_priority > vtime_q)) ? i__dequeue_priority : vtime_q;
   assign ovf_d   = ovf_q | (tbl_we & finish_wide[PRIORITY_WIDTH]);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid_q    <= 1'b0;
         s1_flow_q     <= '0;
         s1_len_q      <= '0;
         enq_q         <= 1'b0;
         prio_q        <= '0;
         flow_q        <= '0;
         vtime_q       <= '0;
         ovf_q         <= 1'b0;
         last_finish_q <= '{default: '0};
      end else begin
         s1_valid_q    <= s1_valid_d;
         s1_flow_q     <= s1_flow_d;
         s1_len_q      <= s1_len_d;
         enq_q         <= enq_d;
         prio_q        <= prio_d;
         flow_q        <= flow_d;
         vtime_q       <= vtime_d;
         ovf_q         <= ovf_d;
         last_finish_q <= last_finish_d;
      end
   end

   assign o__enqueue          = enq_q;
   assign o__enqueue_priority = prio_q;
   assign o__enqueue_flow_id  = flow_q;
   assign o__virtual_time     = vtime_q;
   assign o__overflow         = ovf_q;

endmodule

// File: tb/tb_stfq_rank_compute.sv
// Scoreboard bench for stfq_rank_compute: directed packets push expected ranks, a monitor pops on enqueue.
// Build with STFQ_WEIGHT_EN defined to also exercise the per-flow weight shift.
module tb_stfq_rank_compute;

   logic        clk;
   logic        reset;
   logic        pkt_valid;
   logic        pkt_ready;
   logic [3:0]  pkt_flow_id;
   logic [10:0] pkt_length;
   logic        enqueue;
   logic [15:0] enqueue_priority;
   logic [3:0]  enqueue_flow_id;
   logic        enqueue_ready;
   logic        dequeue_valid;
   logic [15:0] dequeue_priority;
   logic [15:0] virtual_time;
   logic        overflow;
`ifdef STFQ_WEIGHT_EN
   logic        cfg_wr;
   logic [3:0]  cfg_flow_id;
   logic [2:0]  cfg_shift;
`endif

   stfq_rank_compute dut (
      .clk                 (clk),
      .reset               (reset),
      .i__pkt_valid        (pkt_valid),
      .o__pkt_ready        (pkt_ready),
      .i__pkt_flow_id      (pkt_flow_id),
      .i__pkt_length       (pkt_length),
      .o__enqueue          (enqueue),
      .o__enqueue_priority (enqueue_priority),
      .o__enqueue_flow_id  (enqueue_flow_id),
      .i__enqueue_ready    (enqueue_ready),
      .i__dequeue_valid    (dequeue_valid),
      .i__dequeue_priority (dequeue_priority),
      .o__virtual_time     (virtual_time),
`ifdef STFQ_WEIGHT_EN
      .i__cfg_wr           (cfg_wr),
      .i__cfg_flow_id      (cfg_flow_id),
      .i__cfg_shift        (cfg_shift),
`endif
      .o__overflow         (overflow)
   );

   typedef struct {
      logic [3:0]  flow;
      logic [15:0] prio;
   } exp_t;

   exp_t exp_q[$];
   int   pop_cyc[$];
   int   vec_cnt = 0;
   int   err_cnt = 0;
   int   cyc = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   function automatic void check(input string name, input longint act, input longint expv);
      vec_cnt++;
      if (act != expv) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endfunction

   // Monitor: every accepted enqueue must match the oldest expected rank.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset && enqueue && enqueue_ready) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               vec_cnt++;
               err_cnt++;
               $display("FAIL spurious_enq: got flow %0d prio %0d expected no enqueue",
                        enqueue_flow_id, enqueue_priority);
            end else begin
               e = exp_q.pop_front();
               $display("enq cyc=%0d flow=%0d prio=%0d (exp flow=%0d prio=%0d)",
                        cyc, enqueue_flow_id, enqueue_priority, e.flow, e.prio);
               check("enq_flow", enqueue_flow_id, e.flow);
               check("enq_prio", enqueue_priority, e.prio);
            end
         end
      end
   end

   // All driver tasks start and end at posedge+1.
   task automatic idle(input int n);
      pkt_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int flow, input int len, input int prio);
      exp_t e;
      int   tries;
      logic rdy;
      e.flow = flow[3:0];
      e.prio = prio[15:0];
      exp_q.push_back(e);
      pkt_valid   = 1'b1;
      pkt_flow_id = flow[3:0];
      pkt_length  = len[10:0];
      tries = 0;
      do begin
         @(negedge clk);
         rdy = pkt_ready;
         @(posedge clk);
         #1;
         tries++;
      end while (!rdy && tries < 50);
      if (!rdy) begin
         vec_cnt++;
         err_cnt++;
         $display("FAIL accept_timeout: got ready 0 expected 1 for flow %0d", flow);
      end
   endtask

   task automatic deq(input int p);
      dequeue_valid    = 1'b1;
      dequeue_priority = p[15:0];
      @(posedge clk);
      #1;
      dequeue_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      pkt_valid = 1'b0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (exp_q.size() != 0 && n < 200);
      check("drain_left", exp_q.size(), 0);
   endtask

   task automatic check_at_neg(input string name, input int sel, input longint expv);
      @(negedge clk);
      case (sel)
         0:       check(name, virtual_time, expv);
         1:       check(name, overflow, expv);
         default: check(name, enqueue, expv);
      endcase
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset            = 1'b0;
      pkt_valid        = 1'b0;
      pkt_flow_id      = '0;
      pkt_length       = '0;
      enqueue_ready    = 1'b1;
      dequeue_valid    = 1'b0;
      dequeue_priority = '0;
`ifdef STFQ_WEIGHT_EN
      cfg_wr      = 1'b0;
      cfg_flow_id = '0;
      cfg_shift   = '0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_enq", enqueue, 0);
      check("rst_prio", enqueue_priority, 0);
      check("rst_flow", enqueue_flow_id, 0);
      check("rst_vtime", virtual_time, 0);
      check("rst_ovf", overflow, 0);
      check("rst_pkt_ready", pkt_ready, 1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle(1);

      // Back-to-back same flow, consecutive outputs, then read last_finish[3]=150 back via rank.
      pop_cyc.delete();
      send(3, 100, 0);
      send(3, 50, 100);
      drain();
      check("b2b_gap", (pop_cyc.size() == 2) ? (pop_cyc[1] - pop_cyc[0]) : -1, 1);
      send(3, 1, 150);
      drain();

      // Virtual time advance from dequeue.
      send(1, 10, 0);
      idle(2);
      deq(500);
      check_at_neg("vtime_500", 0, 500);
      send(1, 10, 500);
      drain();

      // V never decreases; same-edge dequeue uses pre-edge V.
      deq(200);
      check_at_neg("vtime_hold", 0, 500);
      send(2, 5, 500);
      pkt_valid = 1'b0;
      deq(600);
      check_at_neg("vtime_600", 0, 600);
      drain();

      // Saturation and sticky overflow.
      check_at_neg("ovf_clear", 1, 0);
      deq(65500);
      send(0, 100, 65500);
      idle(3);
      check_at_neg("ovf_set", 1, 1);
      send(0, 0, 65535);
      drain();
      idle(5);
      check_at_neg("ovf_sticky", 1, 1);
      check_at_neg("vtime_65500", 0, 65500);

      // Reset clears V and overflow.
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("rst2_enq", enqueue, 0);
      check("rst2_ovf", overflow, 0);
      check("rst2_vtime", virtual_time, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle(1);

      // Downstream stall for 3 cycles during a 4-packet stream.
      fork
         begin
            send(4, 10, 0);
            send(4, 20, 10);
            send(5, 7, 0);
            send(4, 5, 30);
            pkt_valid = 1'b0;
         end
         begin
            repeat (2) @(posedge clk);
            #1;
            enqueue_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check("stall_enq", enqueue, 1);
               check("stall_prio", enqueue_priority, 0);
               check("stall_flow", enqueue_flow_id, 4);
               check("stall_pkt_ready", pkt_ready, 0);
            end
            @(posedge clk);
            #1;
            enqueue_ready = 1'b1;
         end
      join
      drain();

      // Asynchronous reset mid-stream.
      send(9, 3, 0);
      send(9, 4, 3);
      pkt_valid = 1'b0;
      #2;
      reset = 1'b0;
      exp_q.delete();
      #1;
      check("midrst_enq", enqueue, 0);
      check("midrst_vtime", virtual_time, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle(4);
      check_at_neg("postrst_enq", 2, 0);
      send(3, 10, 0);
      drain();

`ifdef STFQ_WEIGHT_EN
      cfg_wr      = 1'b1;
      cfg_flow_id = 4'd5;
      cfg_shift   = 3'd2;
      @(posedge clk);
      #1;
      cfg_wr = 1'b0;
      send(5, 100, 0);
      send(5, 100, 25);
      drain();
`endif

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
